// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared types and defaults for the write-back unit: load-size encodings,
// geometry defaults and the pending-rd one-hot helper.
package ysyx_23060332_wbu_pkg;

  localparam int WB_ADDR_W     = 5;
  localparam int WB_DATA_W     = 32;
  localparam int WB_STARVE_MAX = 2;

  typedef enum logic [1:0] {
    WB_SIZE_BYTE  = 2'd0,
    WB_SIZE_HALF  = 2'd1,
    WB_SIZE_WORD  = 2'd2,
    WB_SIZE_WORDX = 2'd3
  } wb_size_e;

  // x0 is hardwired, so it never shows up as pending
  function automatic logic [(2**WB_ADDR_W)-1:0] rd_onehot(input logic [WB_ADDR_W-1:0] rd,
                                                          input logic en);
    logic [(2**WB_ADDR_W)-1:0] mask;
    mask = {(2**WB_ADDR_W){1'b0}};
    if (en && (rd != {WB_ADDR_W{1'b0}})) begin
      mask[rd] = 1'b1;
    end else begin
      mask = {(2**WB_ADDR_W){1'b0}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_23060332_wbu_if.sv
// Bundle of the EXU/LSU result handshakes and the register-file write port
// seen by the write-back unit.
interface ysyx_23060332_wbu_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              exu_valid;
  logic              exu_ready;
  logic              exu_wen;
  logic [ADDR_W-1:0] exu_rd;
  logic [DATA_W-1:0] exu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_rdata;
  logic [1:0]        lsu_addr_lo;
  logic [1:0]        lsu_size;
  logic              lsu_unsigned;

  logic                     reg_wen;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     retire;
  logic [(2**ADDR_W)-1:0]   pend_mask;

  modport master (
    output exu_valid, exu_wen, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_size, lsu_unsigned,
    input  exu_ready, lsu_ready, reg_wen, waddr, wdata, retire, pend_mask
  );

  modport slave (
    input  exu_valid, exu_wen, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_rdata, lsu_addr_lo, lsu_size, lsu_unsigned,
    output exu_ready, lsu_ready, reg_wen, waddr, wdata, retire, pend_mask
  );
endinterface

// File: rtl/ysyx_23060332_wbu_slot.sv
// One-entry holding register with valid/ready input; ready also opens in the
// cycle the entry is drained, so a source can stream at full rate.
module ysyx_23060332_wbu_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         drain,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_r;
  logic [W-1:0] data_r;

  assign in_ready = !full_r || drain;
  assign full     = full_r;
  assign data     = data_r;

  // Fill on handshake, empty on drain; a fill in the drain cycle keeps it full
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
      data_r <= {W{1'b0}};
    end else if (in_valid && in_ready) begin
      full_r <= 1'b1;
      data_r <= in_data;
    end else if (drain) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: buffers one EXU and one LSU result, formats load data and
// arbitrates them onto the registered single register-file write port.
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
#(
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input logic clk,
  input logic rst,
  ysyx_23060332_wbu_if.slave wb
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int EXU_W = 1 + ADDR_W + DATA_W;
  localparam int LSU_W = ADDR_W + DATA_W;

  logic [7:0]        byte_sel_s;
  logic [15:0]       half_sel_s;
  logic [DATA_W-1:0] load_data_s;

  logic              exu_ready_s, lsu_ready_s;
  logic              exu_full_s, lsu_full_s;
  logic              exu_drain_s, lsu_drain_s;
  logic [EXU_W-1:0]  exu_q_s;
  logic [LSU_W-1:0]  lsu_q_s;

  logic              sel_wen_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;

  logic [CNT_W-1:0]  starve_cnt_r;
  logic              reg_wen_r, retire_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;

  // Load data formatter: pick byte/half lane and extend
  always_comb begin
    byte_sel_s  = 8'(wb.lsu_rdata >> {wb.lsu_addr_lo, 3'b000});
    half_sel_s  = 16'(wb.lsu_rdata >> {wb.lsu_addr_lo[1], 4'b0000});
    load_data_s = wb.lsu_rdata;
    case (wb_size_e'(wb.lsu_size))
      WB_SIZE_BYTE: begin
        if (wb.lsu_unsigned) begin
          load_data_s = {{(DATA_W-8){1'b0}}, byte_sel_s};
        end else begin
          load_data_s = {{(DATA_W-8){byte_sel_s[7]}}, byte_sel_s};
        end
      end
      WB_SIZE_HALF: begin
        if (wb.lsu_unsigned) begin
          load_data_s = {{(DATA_W-16){1'b0}}, half_sel_s};
        end else begin
          load_data_s = {{(DATA_W-16){half_sel_s[15]}}, half_sel_s};
        end
      end
      default: load_data_s = wb.lsu_rdata;
    endcase
  end

  ysyx_23060332_wbu_slot #(.W(EXU_W)) u_exu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wb.exu_valid),
    .in_ready (exu_ready_s),
    .in_data  ({wb.exu_wen, wb.exu_rd, wb.exu_data}),
    .drain    (exu_drain_s),
    .full     (exu_full_s),
    .data     (exu_q_s)
  );

  ysyx_23060332_wbu_slot #(.W(LSU_W)) u_lsu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wb.lsu_valid),
    .in_ready (lsu_ready_s),
    .in_data  ({wb.lsu_rd, load_data_s}),
    .drain    (lsu_drain_s),
    .full     (lsu_full_s),
    .data     (lsu_q_s)
  );

  assign wb.exu_ready = exu_ready_s;
  assign wb.lsu_ready = lsu_ready_s;

  // Arbiter: LSU has priority until EXU has waited STARVE_MAX cycles
  always_comb begin
    exu_drain_s = 1'b0;
    lsu_drain_s = 1'b0;
    if (exu_full_s && (!lsu_full_s || (starve_cnt_r == CNT_W'(STARVE_MAX)))) begin
      exu_drain_s = 1'b1;
    end else begin
      lsu_drain_s = lsu_full_s;
    end
  end

  // Winner's entry; loads always write their rd
  always_comb begin
    sel_wen_s  = 1'b1;
    sel_rd_s   = lsu_q_s[LSU_W-1 -: ADDR_W];
    sel_data_s = lsu_q_s[DATA_W-1:0];
    if (exu_drain_s) begin
      sel_wen_s  = exu_q_s[EXU_W-1];
      sel_rd_s   = exu_q_s[EXU_W-2 -: ADDR_W];
      sel_data_s = exu_q_s[DATA_W-1:0];
    end else begin
      sel_wen_s  = 1'b1;
    end
  end

  // Starvation counter: counts EXU losses, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (exu_full_s && !exu_drain_s) begin
      if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Register-file write port; waddr/wdata hold when nothing drains
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_r <= 1'b0;
      retire_r  <= 1'b0;
      waddr_r   <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
    end else if (exu_drain_s || lsu_drain_s) begin
      reg_wen_r <= sel_wen_s && (sel_rd_s != {ADDR_W{1'b0}});
      retire_r  <= 1'b1;
      waddr_r   <= sel_rd_s;
      wdata_r   <= sel_data_s;
    end else begin
      reg_wen_r <= 1'b0;
      retire_r  <= 1'b0;
      waddr_r   <= waddr_r;
      wdata_r   <= wdata_r;
    end
  end

  assign wb.reg_wen = reg_wen_r;
  assign wb.retire  = retire_r;
  assign wb.waddr   = waddr_r;
  assign wb.wdata   = wdata_r;

  assign wb.pend_mask = rd_onehot(exu_q_s[EXU_W-2 -: ADDR_W], exu_full_s && exu_q_s[EXU_W-1])
                      | rd_onehot(lsu_q_s[LSU_W-1 -: ADDR_W], lsu_full_s)
                      | rd_onehot(waddr_r, reg_wen_r);

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Directed and randomized self-checking bench for the write-back unit.
module tb_ysyx_23060332_wbu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060332_wbu_if #(.ADDR_W(5), .DATA_W(32)) wb ();

  ysyx_23060332_wbu dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.exu_valid    = 1'b0;
    wb.exu_wen      = 1'b0;
    wb.exu_rd       = 5'd0;
    wb.exu_data     = 32'd0;
    wb.lsu_valid    = 1'b0;
    wb.lsu_rd       = 5'd0;
    wb.lsu_rdata    = 32'd0;
    wb.lsu_addr_lo  = 2'd0;
    wb.lsu_size     = 2'd2;
    wb.lsu_unsigned = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got wen=%0b ret=%0b waddr=%0d wdata=%h want 0 0 0 0",
               wb.reg_wen, wb.retire, wb.waddr, wb.wdata);
    end
    n_checks++;
    if ({wb.exu_ready, wb.lsu_ready, wb.pend_mask} !== {1'b1, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_ready_pend got exu_rdy=%0b lsu_rdy=%0b pend=%h want 1 1 0",
               wb.exu_ready, wb.lsu_ready, wb.pend_mask);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exu_single();
    wb.exu_valid = 1'b1;
    wb.exu_wen   = 1'b1;
    wb.exu_rd    = 5'd5;
    wb.exu_data  = 32'h0000_1234;
    n_checks++;
    if (wb.exu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL exu_single_ready got %0b want 1", wb.exu_ready);
    end
    tick();
    wb.exu_valid = 1'b0;
    n_checks++;
    if ({wb.reg_wen, wb.pend_mask} !== {1'b0, 32'h0000_0020}) begin
      n_fail++;
      $display("FAIL exu_single_held got wen=%0b pend=%h want 0 00000020", wb.reg_wen, wb.pend_mask);
    end
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask} !==
        {1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_0020}) begin
      n_fail++;
      $display("FAIL exu_single_write got wen=%0b ret=%0b waddr=%0d wdata=%h pend=%h want 1 1 5 00001234 00000020",
               wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask);
    end
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask} !==
        {1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0}) begin
      n_fail++;
      $display("FAIL exu_single_after got wen=%0b ret=%0b waddr=%0d wdata=%h pend=%h want 0 0 5 00001234 0",
               wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask);
    end
  endtask

  task automatic test_load_format();
    logic [1:0]  lo_t   [8] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [1:0]  size_t [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
    logic        uns_t  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_t  [8] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h0000_0080, 32'h80FF_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 8; i++) begin
      wb.lsu_valid    = 1'b1;
      wb.lsu_rd       = 5'd3;
      wb.lsu_rdata    = 32'h80FF_7F01;
      wb.lsu_addr_lo  = lo_t[i];
      wb.lsu_size     = size_t[i];
      wb.lsu_unsigned = uns_t[i];
      tick();
      wb.lsu_valid = 1'b0;
      tick();
      n_checks++;
      if ({wb.reg_wen, wb.waddr, wb.wdata} !== {1'b1, 5'd3, exp_t[i]}) begin
        n_fail++;
        $display("FAIL load_format[%0d] got wen=%0b waddr=%0d wdata=%h want 1 3 %h",
                 i, wb.reg_wen, wb.waddr, wb.wdata, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int ei = 0;
    int li = 0;
    int low = 0;
    int k;
    logic e_hs, l_hs;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    wb.exu_valid    = 1'b1;
    wb.exu_wen      = 1'b1;
    wb.exu_rd       = 5'd10;
    wb.exu_data     = 32'hE000_0000;
    wb.lsu_valid    = 1'b1;
    wb.lsu_rd       = 5'd11;
    wb.lsu_rdata    = 32'h1000_0000;
    wb.lsu_size     = 2'd2;
    wb.lsu_unsigned = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      e_hs = wb.exu_valid && wb.exu_ready;
      l_hs = wb.lsu_valid && wb.lsu_ready;
      if (cyc >= 1 && cyc <= 9 && !wb.exu_ready) low++;
      tick();
      if (e_hs) begin
        ei++;
        wb.exu_data = 32'hE000_0000 + 32'(ei);
      end
      if (l_hs) begin
        li++;
        wb.lsu_rdata = 32'h1000_0000 + 32'(li);
      end
      if (cyc >= 1) begin
        k = cyc - 1;
        if (k % 3 == 2) begin
          exp_rd   = 5'd10;
          exp_data = 32'hE000_0000 + 32'(k / 3);
        end else begin
          exp_rd   = 5'd11;
          exp_data = 32'h1000_0000 + 32'(k - k / 3);
        end
        n_checks++;
        if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata} !== {1'b1, 1'b1, exp_rd, exp_data}) begin
          n_fail++;
          $display("FAIL back_to_back[%0d] got wen=%0b ret=%0b waddr=%0d wdata=%h want 1 1 %0d %h",
                   k, wb.reg_wen, wb.retire, wb.waddr, wb.wdata, exp_rd, exp_data);
        end
      end
    end
    n_checks++;
    if (low != 6) begin
      n_fail++;
      $display("FAIL back_to_back_exu_ready_low got %0d want 6 of 9 cycles", low);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_rd_zero();
    wb.exu_valid = 1'b1;
    wb.exu_wen   = 1'b1;
    wb.exu_rd    = 5'd0;
    wb.exu_data  = 32'h0000_DEAD;
    tick();
    wb.exu_valid = 1'b0;
    n_checks++;
    if (wb.pend_mask !== 32'd0) begin
      n_fail++;
      $display("FAIL rd_zero_pend got %h want 0", wb.pend_mask);
    end
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask} !==
        {1'b0, 1'b1, 5'd0, 32'h0000_DEAD, 32'd0}) begin
      n_fail++;
      $display("FAIL rd_zero_out got wen=%0b ret=%0b waddr=%0d wdata=%h pend=%h want 0 1 0 0000dead 0",
               wb.reg_wen, wb.retire, wb.waddr, wb.wdata, wb.pend_mask);
    end
    wb.exu_valid = 1'b1;
    wb.exu_wen   = 1'b0;
    wb.exu_rd    = 5'd9;
    wb.exu_data  = 32'h0000_BEEF;
    tick();
    wb.exu_valid = 1'b0;
    n_checks++;
    if (wb.pend_mask !== 32'd0) begin
      n_fail++;
      $display("FAIL wen_zero_pend got %h want 0", wb.pend_mask);
    end
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.waddr, wb.wdata} !== {1'b0, 1'b1, 5'd9, 32'h0000_BEEF}) begin
      n_fail++;
      $display("FAIL wen_zero_out got wen=%0b ret=%0b waddr=%0d wdata=%h want 0 1 9 0000beef",
               wb.reg_wen, wb.retire, wb.waddr, wb.wdata);
    end
    tick();
  endtask

  task automatic test_pend_reset();
    wb.exu_valid = 1'b1;
    wb.exu_wen   = 1'b1;
    wb.exu_rd    = 5'd7;
    wb.exu_data  = 32'h0000_0077;
    tick();
    wb.exu_valid = 1'b0;
    n_checks++;
    if (wb.pend_mask !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL pend_slot got %h want 00000080", wb.pend_mask);
    end
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.pend_mask} !== {1'b1, 32'h0000_0080}) begin
      n_fail++;
      $display("FAIL pend_out got wen=%0b pend=%h want 1 00000080", wb.reg_wen, wb.pend_mask);
    end
    tick();
    n_checks++;
    if (wb.pend_mask !== 32'd0) begin
      n_fail++;
      $display("FAIL pend_clear got %h want 0", wb.pend_mask);
    end
    wb.exu_valid    = 1'b1;
    wb.exu_data     = 32'h0000_0001;
    wb.lsu_valid    = 1'b1;
    wb.lsu_rd       = 5'd12;
    wb.lsu_rdata    = 32'h0000_0002;
    wb.lsu_size     = 2'd2;
    tick();
    idle_inputs();
    n_checks++;
    if (wb.pend_mask !== 32'h0000_1080) begin
      n_fail++;
      $display("FAIL pend_both got %h want 00001080", wb.pend_mask);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.retire, wb.pend_mask, wb.exu_ready, wb.lsu_ready} !==
        {1'b0, 1'b0, 32'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset got wen=%0b ret=%0b pend=%h exu_rdy=%0b lsu_rdy=%0b want 0 0 0 1 1",
               wb.reg_wen, wb.retire, wb.pend_mask, wb.exu_ready, wb.lsu_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({wb.reg_wen, wb.retire, wb.pend_mask} !== {1'b0, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL after_reset[%0d] got wen=%0b ret=%0b pend=%h want 0 0 0",
                 i, wb.reg_wen, wb.retire, wb.pend_mask);
      end
    end
  endtask

  task automatic test_random();
    logic [36:0] eq[$];
    logic [36:0] lq[$];
    logic [36:0] exp;
    int es = 0;
    int ls = 0;
    logic e_hs, l_hs;
    idle_inputs();
    wb.exu_wen      = 1'b1;
    wb.lsu_size     = 2'd2;
    wb.lsu_unsigned = 1'b1;
    for (int cyc = 0; cyc < 320; cyc++) begin
      wb.exu_rd    = 5'(1 + es % 15);
      wb.exu_data  = 32'hE000_0000 | 32'(es);
      wb.lsu_rd    = 5'(16 + ls % 16);
      wb.lsu_rdata = 32'h5A00_0000 | 32'(ls);
      wb.lsu_addr_lo = 2'($urandom_range(0, 3));
      e_hs = wb.exu_valid && wb.exu_ready;
      l_hs = wb.lsu_valid && wb.lsu_ready;
      if (e_hs) eq.push_back({wb.exu_rd, wb.exu_data});
      if (l_hs) lq.push_back({wb.lsu_rd, wb.lsu_rdata});
      tick();
      if (e_hs) es++;
      if (l_hs) ls++;
      if (cyc < 300) begin
        if (e_hs || !wb.exu_valid) wb.exu_valid = 1'($urandom_range(0, 1));
        if (l_hs || !wb.lsu_valid) wb.lsu_valid = 1'($urandom_range(0, 1));
      end else begin
        wb.exu_valid = 1'b0;
        wb.lsu_valid = 1'b0;
      end
      if (wb.retire === 1'b1) begin
        n_checks++;
        exp = 37'd0;
        if (wb.wdata[31:24] == 8'hE0 && eq.size() > 0) exp = eq.pop_front();
        else if (wb.wdata[31:24] == 8'h5A && lq.size() > 0) exp = lq.pop_front();
        if ({wb.reg_wen, wb.waddr, wb.wdata} !== {1'b1, exp}) begin
          n_fail++;
          $display("FAIL random_out[%0d] got wen=%0b waddr=%0d wdata=%h want 1 %0d %h",
                   cyc, wb.reg_wen, wb.waddr, wb.wdata, exp[36:32], exp[31:0]);
        end
      end
    end
    n_checks++;
    if (eq.size() != 0 || lq.size() != 0 || es < 20 || ls < 20) begin
      n_fail++;
      $display("FAIL random_drained got exu_left=%0d lsu_left=%0d accepted=%0d/%0d want 0 0 >=20 >=20",
               eq.size(), lq.size(), es, ls);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exu_single();
    test_load_format();
    test_back_to_back();
    test_rd_zero();
    test_pend_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
